pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl_sat_counter.sv | 18 +
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM encodings and timing constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam int DRAIN_CYCLES = 3;
   localparam int DRAIN_W      = 2;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/event inputs and stage-control outputs of pipe_ctrl; the pipeline drives through master,
// and the controller uses slave.
interface pipe_ctrl_if #(parameter int CNT_W = 32);

   logic             load_conflict;
   logic             branch_taken;
   logic             mc_start;
   logic             mc_done;
   logic             halt_req;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       state;
   logic             halted;
   logic             mc_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output load_conflict, branch_taken, mc_start, mc_done, halt_req,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
             state, halted, mc_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  load_conflict, branch_taken, mc_start, mc_done, halt_req,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
             state, halted, mc_timeout, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones; one-cycle update latency.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/drain controller; stage controls are combinational from state and inputs.
// Optional perf counters under PIPE_CTRL_PERF_EN; otherwise stall_cnt/flush_cnt read zero.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic        clk,
   input  logic        reset,
   pipe_ctrl_if.slave  bus
);

   localparam int TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(MC_TIMEOUT - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_t              state_q, state_nxt;
   logic                halt_pend_q, halt_pend_nxt;
   logic [TO_W-1:0]     to_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic                if_id_flush, id_ex_bubble, halted, mc_timeout;
   logic [CNT_W-1:0]    stall_cnt, flush_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         halt_pend_q <= halt_pend_nxt;
      end
   end

   // Timeout counter sits at zero outside MC_WAIT so every wait starts from a clean count.
   sat_counter #(.WIDTH(TO_W)) u_to_cnt (
      .clk   (clk),
      .clear (reset || (state_q != ST_MC_WAIT)),
      .inc   (state_q == ST_MC_WAIT),
      .count (to_cnt)
   );

   sat_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
      .clk   (clk),
      .clear (reset || (state_q != ST_DRAIN)),
      .inc   (state_q == ST_DRAIN),
      .count (drain_cnt)
   );

   always_comb begin
      state_nxt     = state_q;
      halt_pend_nxt = halt_pend_q;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      halted        = 1'b0;
      mc_timeout    = 1'b0;
      case (state_q)
         ST_RUN: begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            if (bus.halt_req || halt_pend_q) begin
               state_nxt     = ST_DRAIN;
               halt_pend_nxt = 1'b0;
            end else if (bus.load_conflict) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_bubble = 1'b1;
            end else if (bus.mc_start) begin
               state_nxt = ST_MC_WAIT;
            end else if (bus.branch_taken) begin
               if_id_flush = 1'b1;
            end
         end
         ST_MC_WAIT: begin
            if (bus.halt_req)
               halt_pend_nxt = 1'b1;
            // mc_done only steers the next state here; all enables are already 0 in MC_WAIT.
            if (bus.mc_done || (to_cnt == TO_LAST)) begin
               mc_timeout = !bus.mc_done;
               if (halt_pend_q || bus.halt_req) begin
                  state_nxt     = ST_DRAIN;
                  halt_pend_nxt = 1'b0;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if (drain_cnt == DRAIN_LAST)
               state_nxt = ST_HALT;
         end
         default: begin
            halted = 1'b1;
         end
      endcase
      if (reset) begin
         state_nxt     = ST_RUN;
         halt_pend_nxt = 1'b0;
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         if_id_flush   = 1'b0;
         id_ex_bubble  = 1'b0;
         halted        = 1'b0;
         mc_timeout    = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (!reset && !pc_en && (state_q != ST_HALT)),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (if_id_flush || id_ex_bubble),
      .count (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.ex_mem_en    = ex_mem_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.state        = state_q;
   assign bus.halted       = halted;
   assign bus.mc_timeout   = mc_timeout;
   assign bus.stall_cnt    = stall_cnt;
   assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MC_TIMEOUT=8; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   pipe_ctrl_if #(.CNT_W(32)) bus ();

   pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle's inputs at the falling edge and let combinational outputs settle.
   task automatic step(input logic rst, input logic lc, input logic bt, input logic ms,
                       input logic md, input logic hr);
      @(negedge clk);
      reset             = rst;
      bus.load_conflict = lc;
      bus.branch_taken  = bt;
      bus.mc_start      = ms;
      bus.mc_done       = md;
      bus.halt_req      = hr;
      #1;
   endtask

   function automatic logic [31:0] pc(input int v);
      return PERF ? 32'(v) : 32'd0;
   endfunction

   task automatic chk_en(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en}, {28'd0, exp});
   endtask

   initial begin
      bus.load_conflict = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.mc_start      = 1'b0;
      bus.mc_done       = 1'b0;
      bus.halt_req      = 1'b0;

      // Reset: all controls low.
      step(1, 0, 0, 0, 0, 0);
      chk_en("rst_en", 4'b0000);
      chk("rst_flush", 32'(bus.if_id_flush), 0);
      chk("rst_halted", 32'(bus.halted), 0);
      step(1, 1, 1, 1, 0, 1);
      chk_en("rst_en_ev", 4'b0000);
      chk("rst_bubble", 32'(bus.id_ex_bubble), 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_flush_cnt", bus.flush_cnt, 0);

      // Idle RUN, stray mc_done ignored.
      step(0, 0, 0, 0, 1, 0);
      chk("run_state", 32'(bus.state), 0);
      chk_en("run_en", 4'b1111);
      chk("run_flush", 32'(bus.if_id_flush), 0);
      chk("run_bubble", 32'(bus.id_ex_bubble), 0);

      // Load-use stall.
      step(0, 1, 0, 0, 0, 0);
      chk_en("lc_en", 4'b0011);
      chk("lc_bubble", 32'(bus.id_ex_bubble), 1);
      chk("md_ignored_state", 32'(bus.state), 0);

      // Stall beats branch.
      step(0, 1, 1, 0, 0, 0);
      chk("lcbt_flush_cnt", bus.flush_cnt, pc(1));
      chk_en("lcbt_en", 4'b0011);
      chk("lcbt_flush", 32'(bus.if_id_flush), 0);
      chk("lcbt_bubble", 32'(bus.id_ex_bubble), 1);

      // Branch alone flushes IF/ID.
      step(0, 0, 1, 0, 0, 0);
      chk_en("bt_en", 4'b1111);
      chk("bt_flush", 32'(bus.if_id_flush), 1);
      chk("bt_bubble", 32'(bus.id_ex_bubble), 0);
      chk("bt_stall_cnt", bus.stall_cnt, pc(2));

      // Multi-cycle op, done on 5th wait cycle.
      step(0, 0, 0, 1, 0, 0);
      chk("ms_state", 32'(bus.state), 0);
      chk_en("ms_en", 4'b1111);
      chk("ms_flush_cnt", bus.flush_cnt, pc(3));
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 1, 0, (i == 5), 0);
         chk("mcw_state", 32'(bus.state), 1);
         chk_en("mcw_en", 4'b0000);
         chk("mcw_timeout", 32'(bus.mc_timeout), 0);
      end
      step(0, 0, 0, 0, 0, 0);
      chk("mcd_state", 32'(bus.state), 0);
      chk("mcd_stall_cnt", bus.stall_cnt, pc(7));

      // Timeout after 8 wait cycles.
      step(0, 0, 0, 1, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("to_state", 32'(bus.state), 1);
         chk("to_pulse", 32'(bus.mc_timeout), (i == 8) ? 32'd1 : 32'd0);
      end
      step(0, 0, 0, 0, 0, 0);
      chk("to_after_state", 32'(bus.state), 0);
      chk("to_after_pulse", 32'(bus.mc_timeout), 0);
      chk("to_stall_cnt", bus.stall_cnt, pc(15));

      // Halt latched in MC_WAIT, taken on mc_done.
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("hp_state1", 32'(bus.state), 1);
      step(0, 0, 0, 0, 1, 0);
      chk("hp_state2", 32'(bus.state), 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("drain_state", 32'(bus.state), 2);
         chk_en("drain_en", 4'b0011);
         chk("drain_flush", 32'(bus.if_id_flush), 1);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 1, 1, 1);
         chk("halt_state", 32'(bus.state), 3);
         chk("halt_halted", 32'(bus.halted), 1);
         chk_en("halt_en", 4'b0000);
         chk("halt_flush", 32'(bus.if_id_flush), 0);
      end
      chk("halt_stall_cnt", bus.stall_cnt, pc(20));
      chk("halt_flush_cnt", bus.flush_cnt, pc(6));

      // Leave HALT by reset, then halt from RUN and reset in DRAIN cycle 2.
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rh_state", 32'(bus.state), 0);
      chk("rh_halted", 32'(bus.halted), 0);
      step(0, 0, 0, 0, 0, 0);
      chk("d1_state", 32'(bus.state), 2);
      step(1, 0, 0, 0, 0, 0);
      chk("d2_state", 32'(bus.state), 2);
      chk_en("d2_rst_en", 4'b0000);
      chk("d2_rst_flush", 32'(bus.if_id_flush), 0);
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_state", 32'(bus.state), 0);
      chk("post_rst_halted", 32'(bus.halted), 0);
      chk_en("post_rst_en", 4'b1111);
      chk("post_rst_stall", bus.stall_cnt, 0);
      chk("post_rst_flushc", bus.flush_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
